nexys_starship_repair_code: RTL and testbench

NEXYS_STARSHIP_REPAIR_CODE -- requirements
Module: nexys_starship_repair_code

---
 rtl/nexys_starship_repair_code.sv | 133 +++++++++++++
 tb/tb_nexys_starship_repair_code.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nexys_starship_repair_code.sv
// Repair-challenge engine: issues a pseudo-random hex code to a broken room and
// judges the player's submissions against a try budget and a tick-based deadline.
module nexys_starship_repair_code #(
    parameter int TRIES   = 3,
    parameter int TIMEOUT = 10
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       tick,
    input  logic       play_flag,
    input  logic       gameover_ctrl,
    input  logic       repair_req,
    input  logic       submit,
    input  logic [3:0] hex_combo,
    output logic [3:0] random_hex,
    output logic       challenge_valid,
    output logic       repair_ok,
    output logic       repair_fail,
    output logic [1:0] tries_left,
    output logic [3:0] time_left
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        OK,
        FAIL
    } state_t;

    localparam logic [1:0] TRIES_INIT = 2'(TRIES);
    localparam logic [3:0] TIME_INIT  = 4'(TIMEOUT);
    localparam logic [7:0] LFSR_SEED  = 8'hA5;

    state_t     state;
    logic [7:0] lfsr;

    logic       abort;
    logic       match;
    logic       miss;
    logic       tries_out;
    logic       time_out;
    logic [1:0] tries_next;
    logic [3:0] time_next;
    logic [3:0] capture_hex;

    // Taps 8,6,5,4 give a maximal-length sequence, so a nonzero seed never reaches zero.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    always_comb begin
        abort       = gameover_ctrl | ~play_flag;
        match       = (hex_combo == random_hex);
        miss        = submit & ~match;
        tries_out   = miss & (tries_left == 2'd1);
        time_out    = tick & (time_left == 4'd1);
        tries_next  = tries_left;
        time_next   = time_left;
        if (miss && tries_left != 2'd0) begin
            tries_next = tries_left - 2'd1;
        end
        if (tick && time_left != 4'd0) begin
            time_next = time_left - 4'd1;
        end
        // A challenge equal to the current switches would be solved for free.
        capture_hex = (lfsr[3:0] == hex_combo) ? (lfsr[3:0] ^ 4'hF) : lfsr[3:0];
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state           <= IDLE;
            random_hex      <= 4'h0;
            challenge_valid <= 1'b0;
            repair_ok       <= 1'b0;
            repair_fail     <= 1'b0;
            tries_left      <= 2'd0;
            time_left       <= 4'd0;
        end else begin
            repair_ok   <= 1'b0;
            repair_fail <= 1'b0;
            if (abort) begin
                state           <= IDLE;
                challenge_valid <= 1'b0;
                tries_left      <= 2'd0;
                time_left       <= 4'd0;
            end else begin
                case (state)
                    IDLE: begin
                        if (repair_req) begin
                            state           <= WAIT;
                            random_hex      <= capture_hex;
                            tries_left      <= TRIES_INIT;
                            time_left       <= TIME_INIT;
                            challenge_valid <= 1'b1;
                        end else begin
                            tries_left <= 2'd0;
                            time_left  <= 4'd0;
                        end
                    end
                    WAIT: begin
                        // A correct answer wins even if the deadline tick lands in the same cycle.
                        if (submit && match) begin
                            state           <= OK;
                            repair_ok       <= 1'b1;
                            challenge_valid <= 1'b0;
                        end else begin
                            tries_left <= tries_next;
                            time_left  <= time_next;
                            if (tries_out || time_out) begin
                                state           <= FAIL;
                                repair_fail     <= 1'b1;
                                challenge_valid <= 1'b0;
                            end
                        end
                    end
                    OK, FAIL: begin
                        state      <= IDLE;
                        tries_left <= 2'd0;
                        time_left  <= 4'd0;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_nexys_starship_repair_code.sv
// Randomized self-checking bench for the repair-challenge engine.
module tb_nexys_starship_repair_code;

    localparam int TRIES   = 3;
    localparam int TIMEOUT = 10;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       tick = 1'b0;
    logic       play_flag = 1'b0;
    logic       gameover_ctrl = 1'b0;
    logic       repair_req = 1'b0;
    logic       submit = 1'b0;
    logic [3:0] hex_combo = 4'h0;
    logic [3:0] random_hex;
    logic       challenge_valid;
    logic       repair_ok;
    logic       repair_fail;
    logic [1:0] tries_left;
    logic [3:0] time_left;

    int checks = 0;
    int errors = 0;
    logic [7:0] lfsr_m;
    logic [3:0] exp_hex;

    nexys_starship_repair_code #(.TRIES(TRIES), .TIMEOUT(TIMEOUT)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .tick(tick), .play_flag(play_flag),
        .gameover_ctrl(gameover_ctrl), .repair_req(repair_req), .submit(submit),
        .hex_combo(hex_combo), .random_hex(random_hex), .challenge_valid(challenge_valid),
        .repair_ok(repair_ok), .repair_fail(repair_fail), .tries_left(tries_left),
        .time_left(time_left)
    );

    always #5 Clk = ~Clk;

    // Reference sequence: shift left, feedback = b7^b5^b4^b3 into b0.
    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) lfsr_m <= 8'hA5;
        else          lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
    end

    task automatic step();
        @(posedge Clk);
        #1;
        repair_req = 1'b0;
        submit     = 1'b0;
        tick       = 1'b0;
    endtask

    task automatic start();
        hex_combo = 4'($urandom);
        if ($urandom_range(0, 2) == 0) hex_combo = lfsr_m[3:0];
        exp_hex    = (hex_combo == lfsr_m[3:0]) ? ~lfsr_m[3:0] : lfsr_m[3:0];
        repair_req = 1'b1;
        step();
    endtask

    task automatic test_reset();
        play_flag = 1'b1;
        repair_req = 1'b1;
        step();
        step();
        checks++;
        if ({random_hex, challenge_valid, repair_ok, repair_fail, tries_left, time_left} !== 13'd0) begin
            errors++;
            $display("FAIL reset_outputs: hex=%h v=%b ok=%b fail=%b tries=%0d time=%0d, required all 0",
                     random_hex, challenge_valid, repair_ok, repair_fail, tries_left, time_left);
        end
        checks++;
        if (dut.lfsr !== 8'hA5) begin
            errors++;
            $display("FAIL reset_lfsr: got %h required a5", dut.lfsr);
        end
        Reset_n = 1'b1;
        step();
        checks++;
        if ({challenge_valid, tries_left, time_left} !== 7'd0) begin
            errors++;
            $display("FAIL post_reset_idle: v=%b tries=%0d time=%0d required 0", challenge_valid, tries_left, time_left);
        end
    endtask

    task automatic test_start();
        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(0, 3)) step();
            start();
            checks++;
            if ({challenge_valid, repair_ok, repair_fail, tries_left, time_left, random_hex}
                !== {1'b1, 1'b0, 1'b0, 2'(TRIES), 4'(TIMEOUT), exp_hex} || random_hex == hex_combo) begin
                errors++;
                $display("FAIL start_%0d: v=%b tries=%0d time=%0d hex=%h sw=%h, required v=1 tries=%0d time=%0d hex=%h",
                         i, challenge_valid, tries_left, time_left, random_hex, hex_combo, TRIES, TIMEOUT, exp_hex);
            end
            play_flag = 1'b0;
            step();
            play_flag = 1'b1;
            checks++;
            if ({challenge_valid, repair_ok, repair_fail, tries_left, time_left, random_hex}
                !== {1'b0, 1'b0, 1'b0, 2'd0, 4'd0, exp_hex}) begin
                errors++;
                $display("FAIL play_abort_%0d: v=%b ok=%b fail=%b tries=%0d time=%0d hex=%h required idle hex=%h",
                         i, challenge_valid, repair_ok, repair_fail, tries_left, time_left, random_hex, exp_hex);
            end
        end
    endtask

    task automatic test_ok();
        for (int i = 0; i < 4; i++) begin
            int misses;
            start();
            misses = $urandom_range(0, TRIES - 1);
            for (int m = 1; m <= misses; m++) begin
                hex_combo = exp_hex ^ 4'($urandom_range(1, 15));
                submit = 1'b1;
                step();
                checks++;
                if ({challenge_valid, repair_fail, tries_left} !== {1'b1, 1'b0, 2'(TRIES - m)}) begin
                    errors++;
                    $display("FAIL ok_miss_%0d: v=%b fail=%b tries=%0d required v=1 tries=%0d",
                             m, challenge_valid, repair_fail, tries_left, TRIES - m);
                end
            end
            hex_combo = exp_hex;
            submit = 1'b1;
            tick = 1'($urandom);
            step();
            checks++;
            if ({repair_ok, repair_fail, challenge_valid} !== 3'b100) begin
                errors++;
                $display("FAIL ok_pulse_%0d: ok=%b fail=%b v=%b required ok=1 fail=0 v=0",
                         i, repair_ok, repair_fail, challenge_valid);
            end
            step();
            checks++;
            if ({repair_ok, repair_fail, challenge_valid, tries_left, time_left} !== 9'd0) begin
                errors++;
                $display("FAIL ok_to_idle_%0d: ok=%b fail=%b v=%b tries=%0d time=%0d required all 0",
                         i, repair_ok, repair_fail, challenge_valid, tries_left, time_left);
            end
        end
    endtask

    task automatic test_tries();
        start();
        for (int m = 1; m <= TRIES; m++) begin
            hex_combo = exp_hex ^ 4'($urandom_range(1, 15));
            submit = 1'b1;
            step();
            checks++;
            if (m < TRIES) begin
                if ({challenge_valid, repair_ok, repair_fail, tries_left} !== {3'b100, 2'(TRIES - m)}) begin
                    errors++;
                    $display("FAIL tries_dec_%0d: v=%b ok=%b fail=%b tries=%0d required tries=%0d",
                             m, challenge_valid, repair_ok, repair_fail, tries_left, TRIES - m);
                end
            end else if ({challenge_valid, repair_ok, repair_fail, tries_left, time_left} !== {3'b001, 2'd0, 4'(TIMEOUT)}) begin
                errors++;
                $display("FAIL tries_fail: v=%b ok=%b fail=%b tries=%0d time=%0d required fail=1 tries=0 time=%0d",
                         challenge_valid, repair_ok, repair_fail, tries_left, time_left, TIMEOUT);
            end
        end
        step();
        checks++;
        if ({repair_ok, repair_fail, challenge_valid, tries_left} !== 5'd0) begin
            errors++;
            $display("FAIL tries_single_pulse: ok=%b fail=%b v=%b tries=%0d required 0",
                     repair_ok, repair_fail, challenge_valid, tries_left);
        end
    endtask

    task automatic test_timeout();
        start();
        for (int t = 1; t <= TIMEOUT; t++) begin
            repeat ($urandom_range(0, 2)) step();
            tick = 1'b1;
            step();
            checks++;
            if (t < TIMEOUT) begin
                if ({challenge_valid, repair_fail, time_left} !== {2'b10, 4'(TIMEOUT - t)}) begin
                    errors++;
                    $display("FAIL time_dec_%0d: v=%b fail=%b time=%0d required time=%0d",
                             t, challenge_valid, repair_fail, time_left, TIMEOUT - t);
                end
            end else if ({challenge_valid, repair_ok, repair_fail, time_left, tries_left} !== {3'b001, 4'd0, 2'(TRIES)}) begin
                errors++;
                $display("FAIL time_fail: v=%b ok=%b fail=%b time=%0d tries=%0d required fail=1 time=0 tries=%0d",
                         challenge_valid, repair_ok, repair_fail, time_left, tries_left, TRIES);
            end
        end
        step();
        start();
        repeat (TIMEOUT - 1) begin
            tick = 1'b1;
            step();
        end
        hex_combo = exp_hex ^ 4'($urandom_range(1, 15));
        submit = 1'b1;
        tick = 1'b1;
        step();
        checks++;
        if ({repair_ok, repair_fail, tries_left, time_left} !== {2'b01, 2'(TRIES - 1), 4'd0}) begin
            errors++;
            $display("FAIL tick_and_miss: ok=%b fail=%b tries=%0d time=%0d required fail=1 tries=%0d time=0",
                     repair_ok, repair_fail, tries_left, time_left, TRIES - 1);
        end
        step();
    endtask

    task automatic test_gameover();
        start();
        repeat (TIMEOUT - 5) begin
            tick = 1'b1;
            step();
        end
        hex_combo = exp_hex ^ 4'($urandom_range(1, 15));
        repair_req = 1'b1;
        step();
        checks++;
        if ({random_hex, challenge_valid, tries_left, time_left} !== {exp_hex, 1'b1, 2'(TRIES), 4'd5}) begin
            errors++;
            $display("FAIL req_in_wait: hex=%h v=%b tries=%0d time=%0d required hex=%h v=1 tries=%0d time=5",
                     random_hex, challenge_valid, tries_left, time_left, exp_hex, TRIES);
        end
        gameover_ctrl = 1'b1;
        hex_combo = exp_hex;
        submit = 1'b1;
        step();
        checks++;
        if ({challenge_valid, repair_ok, repair_fail, tries_left, time_left, random_hex} !== {9'd0, exp_hex}) begin
            errors++;
            $display("FAIL gameover_abort: v=%b ok=%b fail=%b tries=%0d time=%0d hex=%h required idle hex=%h",
                     challenge_valid, repair_ok, repair_fail, tries_left, time_left, random_hex, exp_hex);
        end
        repair_req = 1'b1;
        step();
        checks++;
        if ({challenge_valid, repair_ok, repair_fail, tries_left, time_left} !== 9'd0) begin
            errors++;
            $display("FAIL gameover_req_ignored: v=%b tries=%0d time=%0d required 0",
                     challenge_valid, tries_left, time_left);
        end
        gameover_ctrl = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        start();
        #2;
        Reset_n = 1'b0;
        #1;
        checks++;
        if ({random_hex, challenge_valid, repair_ok, repair_fail, tries_left, time_left} !== 13'd0 || dut.lfsr !== 8'hA5) begin
            errors++;
            $display("FAIL async_reset: hex=%h v=%b tries=%0d time=%0d lfsr=%h required 0 and lfsr a5",
                     random_hex, challenge_valid, tries_left, time_left, dut.lfsr);
        end
        step();
        Reset_n = 1'b1;
        repeat ($urandom_range(0, 4)) step();
        start();
        checks++;
        if ({challenge_valid, tries_left, time_left, random_hex} !== {1'b1, 2'(TRIES), 4'(TIMEOUT), exp_hex}) begin
            errors++;
            $display("FAIL fresh_after_reset: v=%b tries=%0d time=%0d hex=%h required hex=%h",
                     challenge_valid, tries_left, time_left, random_hex, exp_hex);
        end
        play_flag = 1'b0;
        step();
        play_flag = 1'b1;
    endtask

    task automatic test_random();
        for (int c = 0; c < 10; c++) begin
            int  tries_m, time_m, n, r;
            bit  done, exp_ok, exp_fail;
            start();
            tries_m = TRIES;
            time_m  = TIMEOUT;
            done    = 1'b0;
            n       = 0;
            while (!done && n < 100) begin
                r = $urandom_range(0, 5);
                submit = (r < 3);
                hex_combo = (r == 0) ? exp_hex : exp_hex ^ 4'($urandom_range(1, 15));
                tick = ($urandom_range(0, 2) == 0);
                exp_ok = 1'b0;
                exp_fail = 1'b0;
                if (submit && r == 0) begin
                    exp_ok = 1'b1;
                end else begin
                    if (submit) tries_m--;
                    if (tick) time_m--;
                    exp_fail = (tries_m == 0) || (time_m == 0);
                end
                done = exp_ok || exp_fail;
                step();
                n++;
                checks++;
                if ({challenge_valid, repair_ok, repair_fail} !== {~done, exp_ok, exp_fail} ||
                    (!exp_ok && {tries_left, time_left} !== {2'(tries_m), 4'(time_m)})) begin
                    errors++;
                    $display("FAIL random_%0d_%0d: v=%b ok=%b fail=%b tries=%0d time=%0d required v=%b ok=%b fail=%b tries=%0d time=%0d",
                             c, n, challenge_valid, repair_ok, repair_fail, tries_left, time_left,
                             ~done, exp_ok, exp_fail, tries_m, time_m);
                end
            end
            if (!done) begin
                checks++;
                errors++;
                $display("FAIL random_%0d_budget: challenge never resolved within 100 cycles", c);
            end
            step();
            checks++;
            if ({challenge_valid, repair_ok, repair_fail, tries_left, time_left} !== 9'd0) begin
                errors++;
                $display("FAIL random_%0d_idle: v=%b ok=%b fail=%b tries=%0d time=%0d required 0",
                         c, challenge_valid, repair_ok, repair_fail, tries_left, time_left);
            end
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_ok();
        test_tries();
        test_timeout();
        test_gameover();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
